// File: rtl/tmr_mode_sequencer_if.sv
// Sensor, fault and status bundle between the dynamic-TMR sequencer and its datapath.
// The master drives sensors and voter faults; the slave (sequencer) drives enables and status.
interface tmr_mode_sequencer_if #(
   parameter int CMD_L = 4
);
   logic             f1;
   logic             f2;
   logic             b1;
   logic             b2;
   logic [CMD_L-1:0] err_rate;
   logic [2:0]       fault;
   logic [2:0]       en;
   logic             state;
   logic [2:0]       isolated;
   logic             failsafe;
   logic             unc_err;
   logic [2:0]       fsm_o;

   modport master (
      output f1, f2, b1, b2, err_rate, fault,
      input  en, state, isolated, failsafe, unc_err, fsm_o
   );

   modport slave (
      input  f1, f2, b1, b2, err_rate, fault,
      output en, state, isolated, failsafe, unc_err, fsm_o
   );
endinterface

// File: rtl/tmr_mode_sequencer.sv
// Sequences the PCC replicas between simplex and voted TMR operation, tracks per-replica
// voter faults, isolates replicas over budget and latches failsafe when redundancy is lost.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_SIMPLEX  | primary replica only, voter passes primary
// S_WARM     | all healthy replicas run to build history, not yet voted
// S_TMR      | healthy replicas voted, fault accounting active
// S_COOL     | still voting, waiting for HOLD_CYC clear cycles
// S_FAILSAFE | at most one healthy replica left; exits only on rst
module tmr_mode_sequencer #(
   parameter int CMD_L     = 4,
   parameter int MAX_ERR   = 5,
   parameter int MAX_FAULT = 5,
   parameter int CNT_W     = 3,
   parameter int WARM_CYC  = 2,
   parameter int HOLD_CYC  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   tmr_mode_sequencer_if.slave   bus
);

   localparam int WC_W = $clog2(WARM_CYC + 1);
   localparam int HC_W = $clog2(HOLD_CYC + 1);
   localparam logic [CMD_L-1:0] ERR_LIM = CMD_L'(MAX_ERR);

   typedef enum logic [2:0] {
      S_SIMPLEX  = 3'd0,
      S_WARM     = 3'd1,
      S_TMR      = 3'd2,
      S_COOL     = 3'd3,
      S_FAILSAFE = 3'd4
   } state_t;

   state_t                  state_r, state_n;
   logic [WC_W-1:0]         warm_r, warm_n;
   logic [HC_W-1:0]         hold_r, hold_n;
   logic [2:0][CNT_W-1:0]   cnt_r, cnt_n;
   logic [2:0]              iso_r, iso_n;
   logic [2:0]              en_r, en_n;
   logic                    vote_r, vote_n;
   logic                    fs_r, fs_n;
   logic                    unc_r, unc_n;

   logic                    trig;
   logic [2:0]              fault_m;
   logic [1:0]              n_flt;
   logic [1:0]              n_iso;
   logic [2:0]              prim_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_SIMPLEX;
         warm_r  <= '0;
         hold_r  <= '0;
         cnt_r   <= '0;
         iso_r   <= 3'b000;
         en_r    <= 3'b001;
         vote_r  <= 1'b0;
         fs_r    <= 1'b0;
         unc_r   <= 1'b0;
      end else begin
         state_r <= state_n;
         warm_r  <= warm_n;
         hold_r  <= hold_n;
         cnt_r   <= cnt_n;
         iso_r   <= iso_n;
         en_r    <= en_n;
         vote_r  <= vote_n;
         fs_r    <= fs_n;
         unc_r   <= unc_n;
      end
   end

   always_comb begin
      state_n = state_r;
      warm_n  = warm_r;
      hold_n  = hold_r;
      cnt_n   = cnt_r;
      iso_n   = iso_r;
      unc_n   = 1'b0;
      prim_n  = 3'b000;
      en_n    = 3'b000;
      vote_n  = 1'b0;
      fs_n    = 1'b0;

      trig    = bus.f1 | bus.f2 | bus.b1 | bus.b2 | (bus.err_rate >= ERR_LIM);
      fault_m = bus.fault & ~iso_r;
      n_flt   = {1'b0, fault_m[0]} + {1'b0, fault_m[1]} + {1'b0, fault_m[2]};
      n_iso   = {1'b0, iso_r[0]} + {1'b0, iso_r[1]} + {1'b0, iso_r[2]};

      // Faults only mean something while the voter is actually comparing replicas.
      if (state_r == S_TMR || state_r == S_COOL) begin
         if (n_flt == 2'd1) begin
            for (int i = 0; i < 3; i++) begin
               if (fault_m[i] && cnt_r[i] != CNT_W'(MAX_FAULT)) begin
                  cnt_n[i] = cnt_r[i] + CNT_W'(1);
                  if (cnt_n[i] == CNT_W'(MAX_FAULT)) iso_n[i] = 1'b1;
               end
            end
         end else if (n_flt > 2'd1) begin
            unc_n = 1'b1;
         end
      end

      if (n_iso >= 2'd2) begin
         state_n = S_FAILSAFE;
      end else begin
         case (state_r)
            S_SIMPLEX: begin
               if (trig) begin
                  state_n = S_WARM;
                  warm_n  = '0;
               end
            end
            S_WARM: begin
               if (!trig) begin
                  state_n = S_SIMPLEX;
               end else begin
                  warm_n = warm_r + WC_W'(1);
                  if (warm_n >= WC_W'(WARM_CYC)) state_n = S_TMR;
               end
            end
            S_TMR: begin
               if (!trig) begin
                  state_n = S_COOL;
                  hold_n  = HC_W'(1);
               end
            end
            S_COOL: begin
               if (trig) begin
                  state_n = S_TMR;
               end else begin
                  hold_n = hold_r + HC_W'(1);
                  if (hold_n >= HC_W'(HOLD_CYC)) state_n = S_SIMPLEX;
               end
            end
            default: state_n = S_FAILSAFE;
         endcase
      end

      if (!iso_n[0])      prim_n = 3'b001;
      else if (!iso_n[1]) prim_n = 3'b010;
      else if (!iso_n[2]) prim_n = 3'b100;

      // Outputs follow the next state and the isolation set that takes effect on this edge.
      case (state_n)
         S_WARM:     en_n = ~iso_n;
         S_TMR,
         S_COOL: begin
            en_n   = ~iso_n;
            vote_n = 1'b1;
         end
         S_FAILSAFE: begin
            en_n = prim_n;
            fs_n = 1'b1;
         end
         default:    en_n = prim_n;
      endcase
   end

   assign bus.en       = en_r;
   assign bus.state    = vote_r;
   assign bus.isolated = iso_r;
   assign bus.failsafe = fs_r;
   assign bus.unc_err  = unc_r;
   assign bus.fsm_o    = state_r;

endmodule

// File: tb/tb_tmr_mode_sequencer.sv
// Self-checking bench for tmr_mode_sequencer: directed scenarios with hand-derived
// expectations, then randomized traffic compared against a mode-level reference model.
module tb_tmr_mode_sequencer;

   localparam int MAX_ERR   = 5;
   localparam int MAX_FAULT = 5;
   localparam int WARM_CYC  = 2;
   localparam int HOLD_CYC  = 4;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   tmr_mode_sequencer_if #(.CMD_L(4)) bus ();

   tmr_mode_sequencer #(
      .CMD_L(4), .MAX_ERR(MAX_ERR), .MAX_FAULT(MAX_FAULT),
      .CNT_W(3), .WARM_CYC(WARM_CYC), .HOLD_CYC(HOLD_CYC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: mode 0..4 = simplex, warm, tmr, cool, failsafe.
   int         m_mode;
   int         m_warm;
   int         m_clear;
   int         m_cnt [3];
   logic [2:0] m_iso;
   logic [2:0] m_en;
   logic       m_vote;
   logic       m_fs;
   logic       m_unc;

   function automatic void model_reset();
      m_mode = 0; m_warm = 0; m_clear = 0;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      m_iso = 3'b000; m_en = 3'b001; m_vote = 1'b0; m_fs = 1'b0; m_unc = 1'b0;
   endfunction

   function automatic void model_update(input bit r, input bit trig, input logic [2:0] flt);
      int         healthy;
      int         nxt;
      logic [2:0] live;
      if (r) begin
         model_reset();
         return;
      end
      healthy = 3 - $countones(m_iso);
      live    = flt & ~m_iso;
      m_unc   = 1'b0;
      if (m_mode == 2 || m_mode == 3) begin
         if ($countones(live) == 1) begin
            for (int i = 0; i < 3; i++) begin
               if (live[i]) begin
                  if (m_cnt[i] < MAX_FAULT) m_cnt[i]++;
                  if (m_cnt[i] >= MAX_FAULT) m_iso[i] = 1'b1;
               end
            end
         end else if ($countones(live) > 1) begin
            m_unc = 1'b1;
         end
      end
      nxt = m_mode;
      if (healthy <= 1) nxt = 4;
      else begin
         case (m_mode)
            0: if (trig) begin nxt = 1; m_warm = 0; end
            1: if (!trig) nxt = 0;
               else begin m_warm++; if (m_warm >= WARM_CYC) nxt = 2; end
            2: if (!trig) begin nxt = 3; m_clear = 1; end
            3: if (trig) nxt = 2;
               else begin m_clear++; if (m_clear >= HOLD_CYC) nxt = 0; end
            default: ;
         endcase
      end
      m_mode = nxt;
      m_vote = (nxt == 2 || nxt == 3);
      m_fs   = (nxt == 4);
      if (nxt == 0 || nxt == 4) begin
         m_en = 3'b000;
         for (int i = 2; i >= 0; i--) if (!m_iso[i]) m_en = 3'(1 << i);
      end else begin
         m_en = ~m_iso;
      end
   endfunction

   // One clock: drive inputs, take the edge, advance the model, settle before sampling.
   task automatic cycle(input bit r, input logic [3:0] sens, input logic [3:0] er,
                        input logic [2:0] flt);
      bit trig;
      rst = r;
      {bus.f1, bus.f2, bus.b1, bus.b2} = sens;
      bus.err_rate = er;
      bus.fault    = flt;
      trig = (|sens) || (er >= MAX_ERR);
      @(posedge clk);
      model_update(r, trig, flt);
      #1;
   endtask

   task automatic reach_tmr();
      cycle(1'b1, 4'b0000, 4'd0, 3'b000);
      repeat (3) cycle(1'b0, 4'b1000, 4'd0, 3'b000);
   endtask

   task automatic test_reset();
      cycle(1'b1, 4'b1111, 4'd15, 3'b111);
      cycle(1'b1, 4'b1111, 4'd15, 3'b111);
      n_checks++;
      if ({bus.fsm_o, bus.en, bus.state, bus.isolated, bus.failsafe, bus.unc_err} !==
          {3'd0, 3'b001, 1'b0, 3'b000, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset: fsm=%0d en=%b state=%b iso=%b fs=%b unc=%b, want 0 001 0 000 0 0",
                  bus.fsm_o, bus.en, bus.state, bus.isolated, bus.failsafe, bus.unc_err);
      end
   endtask

   task automatic test_warm_entry();
      cycle(1'b1, 4'b0000, 4'd0, 3'b000);
      cycle(1'b0, 4'b1000, 4'd0, 3'b000);
      n_checks++;
      if ({bus.fsm_o, bus.en, bus.state} !== {3'd1, 3'b111, 1'b0}) begin
         n_fail++;
         $display("FAIL warm_edge1: fsm=%0d en=%b state=%b, want 1 111 0", bus.fsm_o, bus.en, bus.state);
      end
      cycle(1'b0, 4'b1000, 4'd0, 3'b000);
      n_checks++;
      if (bus.fsm_o !== 3'd1) begin
         n_fail++;
         $display("FAIL warm_edge2: fsm=%0d, want 1", bus.fsm_o);
      end
      cycle(1'b0, 4'b1000, 4'd0, 3'b000);
      n_checks++;
      if ({bus.fsm_o, bus.state} !== {3'd2, 1'b1}) begin
         n_fail++;
         $display("FAIL warm_to_tmr: fsm=%0d state=%b, want 2 1", bus.fsm_o, bus.state);
      end
      // Trigger lost during warm-up falls straight back to simplex.
      cycle(1'b1, 4'b0000, 4'd0, 3'b000);
      cycle(1'b0, 4'b0100, 4'd0, 3'b000);
      cycle(1'b0, 4'b0000, 4'd0, 3'b000);
      n_checks++;
      if ({bus.fsm_o, bus.en} !== {3'd0, 3'b001}) begin
         n_fail++;
         $display("FAIL warm_abort: fsm=%0d en=%b, want 0 001", bus.fsm_o, bus.en);
      end
   endtask

   task automatic test_isolate_one();
      reach_tmr();
      repeat (4) cycle(1'b0, 4'b1000, 4'd0, 3'b010);
      n_checks++;
      if (bus.isolated !== 3'b000) begin
         n_fail++;
         $display("FAIL iso_early: isolated=%b, want 000", bus.isolated);
      end
      cycle(1'b0, 4'b1000, 4'd0, 3'b010);
      n_checks++;
      if ({bus.isolated, bus.en, bus.fsm_o} !== {3'b010, 3'b101, 3'd2}) begin
         n_fail++;
         $display("FAIL iso_fifth: iso=%b en=%b fsm=%0d, want 010 101 2", bus.isolated, bus.en, bus.fsm_o);
      end
      repeat (HOLD_CYC - 1) cycle(1'b0, 4'b0000, 4'd0, 3'b000);
      n_checks++;
      if ({bus.fsm_o, bus.state} !== {3'd3, 1'b1}) begin
         n_fail++;
         $display("FAIL cool_hold: fsm=%0d state=%b, want 3 1", bus.fsm_o, bus.state);
      end
      cycle(1'b0, 4'b0000, 4'd0, 3'b000);
      n_checks++;
      if ({bus.fsm_o, bus.en, bus.state} !== {3'd0, 3'b001, 1'b0}) begin
         n_fail++;
         $display("FAIL cool_exit: fsm=%0d en=%b state=%b, want 0 001 0", bus.fsm_o, bus.en, bus.state);
      end
   endtask

   task automatic test_cool_retrigger();
      reach_tmr();
      repeat (2) cycle(1'b0, 4'b0000, 4'd0, 3'b000);
      cycle(1'b0, 4'b0001, 4'd0, 3'b000);
      n_checks++;
      if ({bus.fsm_o, bus.state} !== {3'd2, 1'b1}) begin
         n_fail++;
         $display("FAIL cool_retrig: fsm=%0d state=%b, want 2 1", bus.fsm_o, bus.state);
      end
      repeat (3) cycle(1'b0, 4'b0000, 4'd0, 3'b000);
      n_checks++;
      if (bus.fsm_o !== 3'd3) begin
         n_fail++;
         $display("FAIL cool_third: fsm=%0d, want 3", bus.fsm_o);
      end
      cycle(1'b0, 4'b0000, 4'd0, 3'b000);
      n_checks++;
      if ({bus.fsm_o, bus.en} !== {3'd0, 3'b001}) begin
         n_fail++;
         $display("FAIL cool_fourth: fsm=%0d en=%b, want 0 001", bus.fsm_o, bus.en);
      end
   endtask

   task automatic test_failsafe();
      reach_tmr();
      repeat (5) cycle(1'b0, 4'b1000, 4'd0, 3'b001);
      repeat (5) cycle(1'b0, 4'b1000, 4'd0, 3'b010);
      n_checks++;
      if ({bus.isolated, bus.en, bus.fsm_o} !== {3'b011, 3'b100, 3'd2}) begin
         n_fail++;
         $display("FAIL fs_second_iso: iso=%b en=%b fsm=%0d, want 011 100 2", bus.isolated, bus.en, bus.fsm_o);
      end
      cycle(1'b0, 4'b0000, 4'd0, 3'b000);
      n_checks++;
      if ({bus.fsm_o, bus.en, bus.state, bus.failsafe} !== {3'd4, 3'b100, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL fs_enter: fsm=%0d en=%b state=%b fs=%b, want 4 100 0 1",
                  bus.fsm_o, bus.en, bus.state, bus.failsafe);
      end
      repeat (4) cycle(1'b0, 4'b0000, 4'd0, 3'b000);
      repeat (3) cycle(1'b0, 4'b1111, 4'd9, 3'b100);
      n_checks++;
      if ({bus.fsm_o, bus.en, bus.isolated, bus.failsafe} !== {3'd4, 3'b100, 3'b011, 1'b1}) begin
         n_fail++;
         $display("FAIL fs_sticky: fsm=%0d en=%b iso=%b fs=%b, want 4 100 011 1",
                  bus.fsm_o, bus.en, bus.isolated, bus.failsafe);
      end
      cycle(1'b1, 4'b0000, 4'd0, 3'b000);
      n_checks++;
      if ({bus.fsm_o, bus.en, bus.isolated, bus.failsafe} !== {3'd0, 3'b001, 3'b000, 1'b0}) begin
         n_fail++;
         $display("FAIL fs_rst: fsm=%0d en=%b iso=%b fs=%b, want 0 001 000 0",
                  bus.fsm_o, bus.en, bus.isolated, bus.failsafe);
      end
   endtask

   task automatic test_unc_err();
      reach_tmr();
      cycle(1'b0, 4'b1000, 4'd0, 3'b011);
      n_checks++;
      if ({bus.unc_err, bus.isolated} !== {1'b1, 3'b000}) begin
         n_fail++;
         $display("FAIL unc_pulse: unc=%b iso=%b, want 1 000", bus.unc_err, bus.isolated);
      end
      cycle(1'b0, 4'b1000, 4'd0, 3'b000);
      n_checks++;
      if (bus.unc_err !== 1'b0) begin
         n_fail++;
         $display("FAIL unc_width: unc=%b, want 0", bus.unc_err);
      end
      repeat (4) cycle(1'b0, 4'b1000, 4'd0, 3'b001);
      n_checks++;
      if (bus.isolated !== 3'b000) begin
         n_fail++;
         $display("FAIL unc_nocount: iso=%b, want 000", bus.isolated);
      end
      cycle(1'b0, 4'b1000, 4'd0, 3'b001);
      n_checks++;
      if ({bus.isolated, bus.en} !== {3'b001, 3'b110}) begin
         n_fail++;
         $display("FAIL unc_then_iso: iso=%b en=%b, want 001 110", bus.isolated, bus.en);
      end
   endtask

   task automatic test_err_rate();
      cycle(1'b1, 4'b0000, 4'd0, 3'b000);
      repeat (3) cycle(1'b0, 4'b0000, 4'd4, 3'b001);
      n_checks++;
      if ({bus.fsm_o, bus.en} !== {3'd0, 3'b001}) begin
         n_fail++;
         $display("FAIL err_below: fsm=%0d en=%b, want 0 001", bus.fsm_o, bus.en);
      end
      cycle(1'b0, 4'b0000, 4'd5, 3'b000);
      n_checks++;
      if (bus.fsm_o !== 3'd1) begin
         n_fail++;
         $display("FAIL err_at_limit: fsm=%0d, want 1", bus.fsm_o);
      end
      repeat (2) cycle(1'b0, 4'b0000, 4'd5, 3'b000);
      repeat (5) cycle(1'b0, 4'b0000, 4'd5, 3'b001);
      repeat (HOLD_CYC) cycle(1'b0, 4'b0000, 4'd0, 3'b000);
      n_checks++;
      if ({bus.fsm_o, bus.en, bus.isolated} !== {3'd0, 3'b010, 3'b001}) begin
         n_fail++;
         $display("FAIL err_new_primary: fsm=%0d en=%b iso=%b, want 0 010 001",
                  bus.fsm_o, bus.en, bus.isolated);
      end
   endtask

   task automatic test_random();
      logic [3:0] sens;
      logic [3:0] er;
      logic [2:0] flt;
      bit         busy;
      bit         r;
      int         pick;
      cycle(1'b1, 4'b0000, 4'd0, 3'b000);
      busy = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 29) == 0) busy = ~busy;
         r    = ($urandom_range(0, 199) == 0);
         sens = 4'b0000;
         er   = 4'($urandom_range(0, 4));
         if ($urandom_range(0, 9) < (busy ? 9 : 1)) begin
            pick = $urandom_range(0, 4);
            if (pick == 4) er = 4'($urandom_range(5, 15));
            else sens = 4'(1 << pick);
         end
         pick = $urandom_range(0, 19);
         if (pick < 4)       flt = 3'(1 << $urandom_range(0, 2));
         else if (pick == 4) flt = 3'($urandom_range(0, 7));
         else                flt = 3'b000;
         cycle(r, sens, er, flt);
         n_checks++;
         if ({bus.fsm_o, bus.en, bus.state, bus.isolated, bus.failsafe, bus.unc_err} !==
             {3'(m_mode), m_en, m_vote, m_iso, m_fs, m_unc}) begin
            n_fail++;
            $display("FAIL random[%0d]: fsm=%0d en=%b st=%b iso=%b fs=%b unc=%b, want %0d %b %b %b %b %b",
                     n, bus.fsm_o, bus.en, bus.state, bus.isolated, bus.failsafe, bus.unc_err,
                     m_mode, m_en, m_vote, m_iso, m_fs, m_unc);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      {bus.f1, bus.f2, bus.b1, bus.b2} = 4'b0000;
      bus.err_rate = 4'd0;
      bus.fault    = 3'b000;
      model_reset();
      test_reset();
      test_warm_entry();
      test_isolate_one();
      test_cool_retrigger();
      test_failsafe();
      test_unc_err();
      test_err_rate();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tmr_mode_sequencer.md
Name: tmr_mode_sequencer

Overview:
- Controller that sequences the dynamic-TMR datapath between simplex and full triple-redundant operation.
- Drives the per-replica enables `en[2:0]` and the voter mode `state` for the three PCC replicas and the majority voter.
- Decides when to enter TMR from the obstacle sensors and the received-data error rate.
- Counts per-replica voter faults, isolates replicas that exceed a fault budget, and falls back to a sticky failsafe when redundancy is lost.

Parameters:
- CMD_L, 4: width of `err_rate`.
- MAX_ERR, 5: `err_rate` at or above this value requests TMR.
- MAX_FAULT, 5: fault count at which a replica is isolated.
- CNT_W, 3: fault counter width; must hold MAX_FAULT.
- WARM_CYC, 2: cycles spent in WARM before voting starts.
- HOLD_CYC, 4: consecutive trigger-free cycles in COOL before returning to simplex.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- f1, f2  in  1 each  front obstacle sensors.
- b1, b2  in  1 each  back obstacle sensors.
- err_rate  in  CMD_L  received-data error rate.
- fault  in  3  voter disagreement flags, one per replica (bit i = replica i).
- en  out  3  replica enables.
- state  out  1  voter mode: 1 = vote, 0 = pass primary.
- isolated  out  3  sticky isolation flags, one per replica.
- failsafe  out  1  sticky loss-of-redundancy flag.
- unc_err  out  1  one-cycle pulse for an uncorrectable voter result.
- fsm_o  out  3  state probe: SIMPLEX=0, WARM=1, TMR=2, COOL=3, FAILSAFE=4.

Behaviour:
- All outputs are registered and update on the same edge as the FSM state.
- Reset values: SIMPLEX, en=001, state=0, isolated=000, failsafe=0, unc_err=0, all fault counters 0, warm and hold counters 0.
- trig = f1 | f2 | b1 | b2 | (err_rate >= MAX_ERR), unsigned compare, sampled each edge.
- Primary replica = lowest-index replica whose isolated bit is 0.
- SIMPLEX:
  - en = one-hot primary, state=0.
  - trig → WARM on the next edge; the warm counter loads 0.
- WARM:
  - en = ~isolated, state=0. Replicas run and track `prev` but are not yet voted.
  - The warm counter increments each cycle. After WARM_CYC cycles in WARM → TMR.
  - trig drops during WARM → SIMPLEX.
- TMR:
  - en = ~isolated, state=1.
  - !trig → COOL; the hold counter loads 1.
- COOL:
  - en = ~isolated, state=1.
  - trig → TMR directly, no warm phase.
  - Otherwise the hold counter increments. When it reaches HOLD_CYC → SIMPLEX.
- Fault accounting runs only in TMR and COOL:
  - Exactly one fault bit set on a non-isolated replica i: cnt[i] increments, saturating at MAX_FAULT.
  - When cnt[i] reaches MAX_FAULT, isolated[i] sets on the same edge and en[i] drops on that edge.
  - Fault bits on already-isolated replicas are ignored.
  - More than one fault bit set among non-isolated replicas: no counter changes; unc_err pulses high for one cycle.
  - In SIMPLEX, WARM and FAILSAFE the fault input is ignored.
- FAILSAFE:
  - Entered on the edge after popcount(isolated) >= 2, from any state; this takes priority over all other transitions.
  - en = one-hot of the remaining healthy replica, state=0, failsafe=1.
  - Exits only on rst; triggers have no effect.
- isolated and the fault counters clear only on rst.
- A rst asserted mid-operation, in any state, returns all outputs to their reset values on that edge.

Test Plan:
1. Reset, then f1=1 held → en=111, state=0, fsm=1 after edge 1; fsm=2 with state=1 after edge 3.
2. In TMR, fault=010 for 5 consecutive cycles → after the 5th edge isolated=010, en=101. Drop triggers → after HOLD_CYC cycles fsm=0, en=001.
3. In COOL, triggers clear for 2 cycles then b2=1 → fsm=2 next edge, state stays 1, no WARM. Separately: hold 4 clear cycles → SIMPLEX.
4. Isolate replica 0 (5 faults), then replica 1 (5 faults) → fsm=4, en=100, state=0, failsafe=1. Stays there with all triggers low; rst → en=001, isolated=000.
5. In TMR, fault=011 for 1 cycle → unc_err=1 for exactly one cycle, counters unchanged. Then 5 single faults on replica 0 are still required for isolation.
6. err_rate=4 with sensors low → stays SIMPLEX. err_rate=5 → WARM. Isolate replica 0, return to SIMPLEX → en=010.
